// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned UART_DATA_OFS = 0;
  localparam int unsigned UART_STAT_OFS = 4;

  // Status register layout
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_EMPTY_BIT = 2;
  localparam int unsigned STAT_COUNT_LSB = 4;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; shared by the UART TX and RX paths.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // Same slot with differing wrap bit means the writer is a full lap ahead
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter sitting between the core data port and Memory.
module uart_mmio_tx
  import uart_pkg::*;
#(
  parameter int unsigned          WORD_LEN   = 32,
  parameter int unsigned          CLK_DIV    = 78,
  parameter int unsigned          FIFO_DEPTH = 16,
  parameter logic [WORD_LEN-1:0]  UART_BASE  = 32'hFFFF_FF00
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_LEN-1:0] core_d_addr,
  input  logic                core_wen,
  input  logic [WORD_LEN-1:0] core_wmask,
  input  logic [WORD_LEN-1:0] core_wdata,
  output logic [WORD_LEN-1:0] core_rdata,
  output logic                core_ready,
  output logic [WORD_LEN-1:0] mem_d_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wmask,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  input  logic                mem_ready,
  output logic                txd,
  output logic                tx_busy
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [WORD_LEN-1:0] L_DATA_ADDR = UART_BASE + WORD_LEN'(UART_DATA_OFS);
  localparam logic [WORD_LEN-1:0] L_STAT_ADDR = UART_BASE + WORD_LEN'(UART_STAT_OFS);
  localparam logic [BAUD_W-1:0]   L_BAUD_TERM = BAUD_W'(CLK_DIV - 1);

  tx_state_t                     r_state;
  logic [UART_DATA_BITS-1:0]     r_shreg;
  logic [2:0]                    r_bit_idx;
  logic [BAUD_W-1:0]             r_baud;

  logic                          w_hit_data;
  logic                          w_hit_stat;
  logic                          w_hit;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_baud_done;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [CNT_W-1:0]              w_fifo_count;
  logic [UART_DATA_BITS-1:0]     w_fifo_rdata;
  logic [WORD_LEN-1:0]           w_status;

  assign w_hit_data = (core_d_addr == L_DATA_ADDR);
  assign w_hit_stat = (core_d_addr == L_STAT_ADDR);
  assign w_hit      = w_hit_data | w_hit_stat;

  assign mem_d_addr = core_d_addr;
  assign mem_wmask  = core_wmask;
  assign mem_wdata  = core_wdata;
  assign mem_wen    = core_wen & ~w_hit;

  // A full FIFO stalls the push even when the serializer pops in the same cycle
  assign w_push = core_wen & w_hit_data & ~w_fifo_full;

  assign w_baud_done = (r_baud == L_BAUD_TERM);
  assign w_pop = ~w_fifo_empty &
                 ((r_state == IDLE) | ((r_state == STOP) & w_baud_done));

  assign tx_busy = (r_state != IDLE) | ~w_fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (core_wdata[UART_DATA_BITS-1:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_status                            = '0;
    w_status[STAT_BUSY_BIT]             = tx_busy;
    w_status[STAT_FULL_BIT]             = w_fifo_full;
    w_status[STAT_EMPTY_BIT]            = w_fifo_empty;
    w_status[STAT_COUNT_LSB +: CNT_W]   = w_fifo_count;
  end

  always_comb begin
    core_rdata = mem_rdata;
    core_ready = mem_ready;
    if (w_hit_stat) begin
      core_rdata = w_status;
      core_ready = 1'b1;
    end else if (w_hit_data) begin
      core_rdata = '0;
      core_ready = core_wen ? ~w_fifo_full : 1'b1;
    end
  end

  always_comb begin
    case (r_state)
      START:   txd = 1'b0;
      DATA:    txd = r_shreg[0];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shreg <= w_fifo_rdata;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_shreg   <= r_shreg >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            // Chain straight into the next start bit for a zero-gap stream
            if (w_pop) begin
              r_shreg <= w_fifo_rdata;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Scoreboard bench for uart_mmio_tx: bus stimulus pushes expected bytes, a txd monitor decodes frames.
module tb_uart_mmio_tx;

  localparam int unsigned CLK_DIV   = 78;
  localparam int          FRAME     = 10 * CLK_DIV;
  localparam logic [31:0] DATA_ADDR = 32'hFFFF_FF00;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_FF04;
  localparam logic [31:0] MEM_ADDR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] core_d_addr;
  logic        core_wen;
  logic [31:0] core_wmask;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic [31:0] mem_d_addr;
  logic        mem_wen;
  logic [31:0] mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        txd;
  logic        tx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames_seen = 0;
  logic [7:0] sb_q[$];
  int         fs_q[$];
  logic [31:0] tb_word;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_mmio_tx #(
    .WORD_LEN   (32),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (16),
    .UART_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_d_addr (core_d_addr),
    .core_wen    (core_wen),
    .core_wmask  (core_wmask),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .core_ready  (core_ready),
    .mem_d_addr  (mem_d_addr),
    .mem_wen     (mem_wen),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .txd         (txd),
    .tx_busy     (tx_busy)
  );

  // One-word stand-in for Memory; every other address reads a fixed pattern
  always @(posedge clk) if (mem_wen && mem_d_addr == MEM_ADDR) tb_word <= mem_wdata;
  assign mem_rdata = (mem_d_addr == MEM_ADDR) ? tb_word : 32'hA5A5_5A5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: decode each frame cycle by cycle and compare against the scoreboard
  initial begin : monitor
    logic [7:0] got;
    logic       first;
    logic       start_l;
    logic       stop_l;
    int         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || txd !== 1'b0) continue;
      frames_seen++;
      fs_q.push_back(cyc);
      bad = 0; aborted = 0; got = '0; start_l = 1'b1; stop_l = 1'b0; first = 1'b0;
      for (int b = 0; b < 10 && !aborted; b++) begin
        for (int c = 0; c < int'(CLK_DIV); c++) begin
          if (b != 0 || c != 0) begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin aborted = 1; break; end
          end
          if (c == 0) first = txd;
          else if (txd !== first) bad++;
        end
        if (!aborted) begin
          if (b == 0)      start_l = first;
          else if (b == 9) stop_l = first;
          else             got[b-1] = first;
        end
      end
      if (aborted) continue;
      check("frame_start_bit", 32'(start_l), 32'h0);
      check("frame_stop_bit", 32'(stop_l), 32'h1);
      check("frame_bit_hold", 32'(bad), 32'h0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=%h required=no_frame", got);
      end else begin
        check("frame_byte", 32'(got), 32'(sb_q.pop_front()));
      end
    end
  end

  // Bus tasks enter and leave at posedge+1 so consecutive calls are back-to-back
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           output int acc_cyc, output int stalls);
    core_d_addr = addr; core_wdata = data; core_wen = 1'b1;
    stalls = 0; acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (core_ready === 1'b1) begin acc_cyc = cyc; break; end
      stalls++;
      if (stalls > 2000) begin
        checks++; failures++;
        $display("FAIL write_timeout actual=stalled required=accept addr=%h", addr);
        break;
      end
      @(posedge clk); #1;
    end
    if (acc_cyc >= 0 && addr == DATA_ADDR) sb_q.push_back(data[7:0]);
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    core_d_addr = addr; core_wen = 1'b0;
    @(negedge clk);
    data = core_rdata; rdy = core_ready;
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    core_wen = 1'b0; core_d_addr = 32'h0000_0200;
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_idle(input string name, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (tx_busy === 1'b0) break;
      n++;
    end
    check(name, 32'(n >= budget), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (frames_seen >= target) break;
      n++;
    end
    check("wait_frames_timeout", 32'(n >= budget), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        rdy;
    int          c;
    int          st;
    int          st2;
    int          base;
    core_d_addr = '0; core_wen = 1'b0; core_wmask = '1; core_wdata = '0; mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", 32'(txd), 32'h1);
    check("reset_busy", 32'(tx_busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    bus_read(STAT_ADDR, rd, rdy);
    check("stat_after_reset", rd, 32'h0000_0004);
    check("stat_ready", 32'(rdy), 32'h1);
    bus_read(DATA_ADDR, rd, rdy);
    check("data_reg_read", rd, 32'h0);
    check("data_reg_ready", 32'(rdy), 32'h1);

    core_d_addr = STAT_ADDR; core_wen = 1'b1; core_wdata = 32'h0000_00FF;
    @(negedge clk);
    check("stat_write_ready", 32'(core_ready), 32'h1);
    check("stat_write_mem_wen", 32'(mem_wen), 32'h0);
    @(posedge clk); #1;
    core_wen = 1'b0;
    bus_read(STAT_ADDR, rd, rdy);
    check("stat_write_ignored", rd, 32'h0000_0004);

    // Pass-through write, first with Memory not ready
    core_d_addr = MEM_ADDR; core_wen = 1'b1; core_wdata = 32'hDEAD_BEEF;
    core_wmask = 32'h0000_FFFF; mem_ready = 1'b0;
    @(negedge clk);
    check("pt_ready_follows_mem", 32'(core_ready), 32'h0);
    check("pt_mem_wen", 32'(mem_wen), 32'h1);
    check("pt_mem_addr", mem_d_addr, MEM_ADDR);
    check("pt_mem_wmask", mem_wmask, 32'h0000_FFFF);
    check("pt_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("pt_ready", 32'(core_ready), 32'h1);
    @(posedge clk); #1;
    core_wen = 1'b0; core_wmask = '1;
    bus_read(MEM_ADDR, rd, rdy);
    check("pt_readback", rd, 32'hDEAD_BEEF);
    check("pt_read_ready", 32'(rdy), 32'h1);
    bus_read(STAT_ADDR, rd, rdy);
    check("pt_fifo_untouched", rd, 32'h0000_0004);

    // Single byte 0x55
    base = frames_seen;
    bus_write(DATA_ADDR, 32'h0000_0155, c, st);
    bus_idle();
    check("w55_no_stall", 32'(st), 32'h0);
    wait_tx_idle("w55_idle_timeout", 2000);
    check("w55_frames", 32'(frames_seen - base), 32'h1);
    if (frames_seen > base) check("w55_latency", 32'(fs_q[base] - c), 32'h2);

    // Two queued bytes: zero gap between frames
    base = frames_seen;
    bus_write(DATA_ADDR, 32'h0000_00A3, c, st);
    bus_write(DATA_ADDR, 32'h0000_003C, c, st2);
    bus_idle();
    check("b2b_no_stall", 32'(st + st2), 32'h0);
    wait_tx_idle("b2b_idle_timeout", 3000);
    check("b2b_frames", 32'(frames_seen - base), 32'h2);
    if (frames_seen >= base + 2) check("b2b_gap", 32'(fs_q[base+1] - fs_q[base]), 32'(FRAME));

    // One byte in flight, then 17 back-to-back: 16 fill the FIFO, the 17th waits for the next pop
    base = frames_seen;
    bus_write(DATA_ADDR, 32'h0000_0011, c, st);
    bus_idle();
    wait_cycles(5);
    for (int i = 0; i < 16; i++) begin
      bus_write(DATA_ADDR, 32'(8'h20 + i), c, st);
      check("burst_no_stall", 32'(st), 32'h0);
    end
    bus_write(DATA_ADDR, 32'h0000_00C7, c, st);
    if (frames_seen > base) check("burst17_accept_cycle", 32'(c), 32'(fs_q[base] + FRAME));
    bus_read(STAT_ADDR, rd, rdy);
    check("stat_full", rd, 32'h0000_0103);
    bus_idle();
    wait_tx_idle("burst_idle_timeout", 20000);
    check("burst_frames", 32'(frames_seen - base), 32'd18);

    // Reset in the middle of the second of three frames
    base = frames_seen;
    bus_write(DATA_ADDR, 32'h0000_005A, c, st);
    bus_write(DATA_ADDR, 32'h0000_00C3, c, st);
    bus_write(DATA_ADDR, 32'h0000_000F, c, st);
    bus_idle();
    wait_frames(base + 2, 3000);
    wait_cycles(200);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'h1);
    check("midrst_busy", 32'(tx_busy), 32'h0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_read(STAT_ADDR, rd, rdy);
    check("midrst_stat", rd, 32'h0000_0004);
    wait_cycles(2000);
    check("midrst_no_frames", 32'(frames_seen - base), 32'h2);
    check("midrst_idle", 32'(tx_busy), 32'h0);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
